// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Control FSM for a UART receiver. It waits for a start bit that holds low
//   long enough, starts the external bit timer, checks the stop bit at the end
//   of the packet, and loads the received byte into the RX buffer.
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   serial_in      synchronized serial line, idle high
//   shift_strobe   bit-period strobe from the bit timer (consumed by the shift
//                  register, not by this FSM)
//   packet_done    one-cycle pulse when the bit timer has counted 9 strobes
//   stop_bit       stop-bit value captured by the shift register
//   data_read      host acknowledge of the buffered byte
//   enable_timer   bit timer enable (high only while receiving)
//   timer_clear    one-cycle clear to the bit timer counters
//   load_buffer    one-cycle load of the shift-register byte into the buffer
//   data_ready     buffered byte valid
//   overrun_error  sticky: a byte was overwritten before being read
//   framing_error  last packet had a 0 stop bit
//   state_dbg      current FSM state encoding
//
// Buffer handshake: data_ready is the valid, data_read is the acknowledge.
// The host may raise data_read on any cycle; the byte is consumed on every
// cycle where data_ready and data_read are both high. A load in the same cycle
// as an acknowledge replaces the consumed byte, so data_ready stays high and
// no overrun is flagged. A load while data_ready is high and unacknowledged
// overwrites the byte and sets overrun_error.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int unsigned START_HOLD = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic       shift_strobe,
  input  logic       packet_done,
  input  logic       stop_bit,
  input  logic       data_read,
  output logic       enable_timer,
  output logic       timer_clear,
  output logic       load_buffer,
  output logic       data_ready,
  output logic       overrun_error,
  output logic       framing_error,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    CLEAR     = 3'd2,
    RECEIVE   = 3'd3,
    STOP_CHK  = 3'd4,
    LOAD      = 3'd5
  } state_t;

  localparam logic [3:0] HOLD = 4'(START_HOLD);

  state_t     state, next_state;
  logic       prev;
  logic [3:0] hold_cnt, hold_cnt_next;
  logic       start_edge;

  // The strobe drives the shift register directly; the FSM only follows
  // packet_done, so the strobe is deliberately left unconsumed here.
  logic unused_strobe;
  assign unused_strobe = shift_strobe;

  assign start_edge = prev & ~serial_in;

  // State register, previous-line register and hold counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      prev     <= 1'b1;
      hold_cnt <= 4'd0;
    end else begin
      state    <= next_state;
      prev     <= serial_in;
      hold_cnt <= hold_cnt_next;
    end
  end

  // Next-state logic. The falling-edge cycle itself counts as the first low
  // cycle (counter loaded with 1); the state advances to CLEAR from the
  // START_CHK cycle in which the counter has reached START_HOLD.
  always_comb begin
    next_state    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      IDLE: begin
        if (start_edge) begin
          next_state    = START_CHK;
          hold_cnt_next = 4'd1;
        end
      end
      START_CHK: begin
        if (serial_in) begin
          next_state = IDLE;                // false start
        end else if (hold_cnt >= HOLD) begin
          next_state = CLEAR;
        end else begin
          hold_cnt_next = hold_cnt + 4'd1;
        end
      end
      CLEAR:    next_state = RECEIVE;
      RECEIVE:  if (packet_done) next_state = STOP_CHK;
      STOP_CHK: next_state = stop_bit ? LOAD : IDLE;
      LOAD:     next_state = IDLE;
      default:  next_state = IDLE;          // unused encodings recover
    endcase
  end

  // Moore outputs.
  assign enable_timer = (state == RECEIVE);
  assign timer_clear  = (state == CLEAR);
  assign load_buffer  = (state == LOAD);
  assign state_dbg    = state;

  // Status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        framing_error <= 1'b0;
      end else if ((state == STOP_CHK) && !stop_bit) begin
        framing_error <= 1'b1;
      end

      if (load_buffer) begin
        data_ready <= 1'b1;
        if (data_ready && !data_read) begin
          overrun_error <= 1'b1;            // previous byte lost
        end else if (data_read) begin
          overrun_error <= 1'b0;
        end
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule
